// File: rtl/fetch_if.sv
// fetch_if: instruction-memory and decode handshake bundle for the fetch path.
//   imem_req/imem_addr/imem_ack/imem_rdata : word read request to instruction memory
//   instr_valid/instr_ready/instr/instr_pc : fetched instruction offered to decode
//   redirect_valid/kind/base/imm           : flow change reported by decode at accept
// The master modport is the fetch controller; the slave modport is memory plus decode.
interface fetch_if #(
    parameter int DBITS               = 32,
    parameter int IMEM_ADDR_BIT_WIDTH = 11
);
    logic                           imem_req;
    logic [IMEM_ADDR_BIT_WIDTH-1:0] imem_addr;
    logic                           imem_ack;
    logic [DBITS-1:0]               imem_rdata;
    logic                           instr_valid;
    logic                           instr_ready;
    logic [DBITS-1:0]               instr;
    logic [DBITS-1:0]               instr_pc;
    logic                           redirect_valid;
    logic                           redirect_kind;
    logic [DBITS-1:0]               redirect_base;
    logic [DBITS-1:0]               redirect_imm;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_ack, imem_rdata, instr_ready,
               redirect_valid, redirect_kind, redirect_base, redirect_imm
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_ack, imem_rdata, instr_ready,
               redirect_valid, redirect_kind, redirect_base, redirect_imm
    );
endinterface

// File: rtl/fetch_controller.sv
// fetch_controller: stall-aware instruction-fetch sequencer.
// Owns the program counter, issues one word read at a time to a variable-latency
// instruction memory, holds each fetched instruction until decode accepts it and
// applies branch/JAL redirects and halt at that accept.
// Ports:
//   clk      : system clock, rising edge
//   reset    : asynchronous active-low reset
//   fif      : fetch_if master (imem request/ack, decode valid/ready, redirect inputs)
//   halt     : level request to stop fetching at the next instruction boundary
//   pc       : address of the current or next request
//   retired  : count of accepted instructions, wraps mod 2^DBITS
module fetch_controller #(
    parameter int               DBITS               = 32,
    parameter logic [DBITS-1:0] START_PC            = 32'h40,
    parameter logic [DBITS-1:0] INST_SIZE           = 32'd4,
    parameter int               IMEM_ADDR_BIT_WIDTH = 11
) (
    input  logic             clk,
    input  logic             reset,
    fetch_if.master          fif,
    input  logic             halt,
    output logic [DBITS-1:0] pc,
    output logic [DBITS-1:0] retired
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_HOLD   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam logic [DBITS-1:0] WORD_MASK = {{(DBITS-2){1'b1}}, 2'b00};

    state_t                         state_r;
    logic [DBITS-1:0]               pc_r;
    logic [IMEM_ADDR_BIT_WIDTH-1:0] imem_addr_r;
    logic [DBITS-1:0]               instr_r;
    logic [DBITS-1:0]               instr_pc_r;
    logic [DBITS-1:0]               retired_r;
    logic [DBITS-1:0]               offset_s;
    logic [DBITS-1:0]               raw_target_s;
    logic [DBITS-1:0]               target_s;
    logic                           accept_s;

    // Word-aligned sum; every redirect target is forced onto a word boundary.
    function automatic logic [DBITS-1:0] align_word(input logic [DBITS-1:0] a,
                                                    input logic [DBITS-1:0] b);
        return (a + b) & WORD_MASK;
    endfunction

    // Next PC after the held instruction is accepted (sequential, branch or JAL).
    always_comb begin
        offset_s     = fif.redirect_imm << 2;
        raw_target_s = instr_pc_r + INST_SIZE;
        if (!fif.redirect_valid) begin
            raw_target_s = instr_pc_r + INST_SIZE;
        end else if (!fif.redirect_kind) begin
            raw_target_s = instr_pc_r + DBITS'(3'd4) + offset_s;
        end else begin
            raw_target_s = fif.redirect_base + offset_s;
        end
        target_s = align_word(raw_target_s, {DBITS{1'b0}});
    end

    assign accept_s = (state_r == ST_HOLD) && fif.instr_ready;

    // Sequencer state, PC and instruction registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            pc_r        <= START_PC;
            imem_addr_r <= START_PC[IMEM_ADDR_BIT_WIDTH+1:2];
            instr_r     <= {DBITS{1'b0}};
            instr_pc_r  <= {DBITS{1'b0}};
            retired_r   <= {DBITS{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= halt ? ST_HALTED : ST_REQ;
                end
                ST_REQ: begin
                    // Halt does not abort an outstanding read; it waits for accept.
                    if (fif.imem_ack) begin
                        instr_r    <= fif.imem_rdata;
                        instr_pc_r <= pc_r;
                        state_r    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (accept_s) begin
                        retired_r   <= retired_r + DBITS'(1'b1);
                        pc_r        <= target_s;
                        imem_addr_r <= target_s[IMEM_ADDR_BIT_WIDTH+1:2];
                        state_r     <= halt ? ST_HALTED : ST_REQ;
                    end
                end
                ST_HALTED: begin
                    if (!halt) begin
                        state_r <= ST_REQ;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake strobes are pure decodes of the state register.
    assign fif.imem_req    = (state_r == ST_REQ);
    assign fif.instr_valid = (state_r == ST_HOLD);
    assign fif.imem_addr   = imem_addr_r;
    assign fif.instr       = instr_r;
    assign fif.instr_pc    = instr_pc_r;
    assign pc              = pc_r;
    assign retired         = retired_r;

endmodule
